// File: rtl/serial_add_sched_pkg.sv
// rtl/serial_add_sched_pkg.sv - shared state encoding and client constants for the serial adder scheduler
package serial_add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    function automatic logic [1:0] client_onehot(input logic idx);
        return (idx == CLIENT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/serial_add_sched_fa.sv
// rtl/serial_add_sched_fa.sv - single-bit full-adder cell
module serial_add_sched_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin two-client bit-serial adder sharing one full-adder cell
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [1:0]   done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic          owner;
    logic          owner_sel;
    logic          last_served;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  ss;
    logic          carry;
    logic [CW-1:0] count;
    logic          fa_s;
    logic          fa_co;
    logic          any_req;
    logic [N-1:0]  ss_shifted;

    serial_add_sched_fa u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign any_req    = req0 | req1;
    assign ss_shifted = {fa_s, ss[N-1:1]};

    // Arbitration: a lone requester wins; on a tie the client not served last wins.
    always_comb begin
        owner_sel = CLIENT0;
        if (req0 && req1) begin
            owner_sel = ~last_served;
        end else if (req1) begin
            owner_sel = CLIENT1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept, run N bits, hold DONE for exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_RUN;
            ST_RUN:  if (count == LAST_BIT) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, LSB-first shifting, result capture and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= CLIENT0;
            last_served <= CLIENT1;
            sa          <= '0;
            sb          <= '0;
            ss          <= '0;
            carry       <= 1'b0;
            count       <= '0;
            sum         <= '0;
            cout        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner <= owner_sel;
                        sa    <= (owner_sel == CLIENT1) ? a1 : a0;
                        sb    <= (owner_sel == CLIENT1) ? b1 : b0;
                        carry <= 1'b0;
                        count <= '0;
                    end
                end
                ST_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    ss    <= ss_shifted;
                    carry <= fa_co;
                    count <= count + CW'(1);
                    // Capture on the final bit so sum/cout are valid alongside done.
                    if (count == LAST_BIT) begin
                        sum  <= ss_shifted;
                        cout <= fa_co;
                    end
                end
                ST_DONE: begin
                    last_served <= owner;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from state and the current owner.
    always_comb begin
        gnt  = 2'b00;
        busy = 1'b0;
        done = 2'b00;
        if (state == ST_RUN || state == ST_DONE) begin
            gnt  = client_onehot(owner);
            busy = 1'b1;
        end
        if (state == ST_DONE) begin
            done = client_onehot(owner);
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench for the serial adder scheduler
module tb_serial_add_sched;

    localparam int N = 8;

    typedef struct {
        logic       client;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    typedef struct {
        logic       client;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic [1:0]   gnt;
    logic         busy;
    logic [1:0]   done;
    logic [N-1:0] sum;
    logic         cout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[6];

    serial_add_sched #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] oh(input logic c);
        return c ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic c, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] full;
        full     = {1'b0, a} + {1'b0, b};
        e.client = c;
        e.sum    = full[7:0];
        e.cout   = full[8];
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One single-client operation; checks grant, busy and the N+1 cycle latency.
    task automatic run_op(input logic c, input logic [7:0] a, input logic [7:0] b);
        int n;
        logic gnt_ok;
        @(negedge clk);
        if (c) begin req1 = 1'b1; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; end
        push_exp(c, a, b);
        @(posedge clk);
        @(negedge clk);
        n = 1;
        check("gnt_after_accept", {30'd0, gnt}, {30'd0, oh(c)});
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        gnt_ok = 1'b1;
        while (!done[c] && n < 30) begin
            if (gnt !== oh(c)) gnt_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("done_latency", n, 9);
        check("gnt_held", {31'd0, gnt_ok}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        int t0, t1, n, pulses;
        logic busy_seen;

        vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'h80, 8'h7F, 8'hFF, 1'b0};
        vecs[5] = '{1'b1, 8'hC3, 8'h3D, 8'h00, 1'b1};

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Scoreboard monitor: pops the expected result whenever done pulses.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    checks++;
                    if (!$onehot0(gnt) || done == 2'b11) begin
                        errors++;
                        $display("FAIL invariant: gnt=%b done=%b", gnt, done);
                    end
                    if (done != 2'b00) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: done=%b sum=%0h", done, sum);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            check("sb_client", {30'd0, done}, {30'd0, oh(e.client)});
                            check("sb_sum", {24'd0, sum}, {24'd0, e.sum});
                            check("sb_cout", {31'd0, cout}, {31'd0, e.cout});
                        end
                    end
                end
            end
        join_none

        do_reset();
        mon_en = 1'b1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);

        // Table-driven single-client operations, with table sum/cout cross-checked too.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].client, vecs[i].a, vecs[i].b);
            check("tbl_sum", {24'd0, sum}, {24'd0, vecs[i].sum});
            check("tbl_cout", {31'd0, cout}, {31'd0, vecs[i].cout});
        end

        // Simultaneous requests right after reset: client 0 first, client 1 ten cycles later.
        do_reset();
        @(negedge clk);
        a0 = 8'h10; b0 = 8'h20; a1 = 8'h80; b1 = 8'h80;
        req0 = 1'b1; req1 = 1'b1;
        push_exp(1'b0, 8'h10, 8'h20);
        push_exp(1'b1, 8'h80, 8'h80);
        t0 = -1; t1 = -1; n = 0;
        while (t1 < 0 && n < 60) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done[0] && t0 < 0) begin t0 = cyc; req0 = 1'b0; end
            if (done[1]) begin t1 = cyc; req1 = 1'b0; end
        end
        check("tie_done0_seen", {31'd0, (t0 >= 0)}, 32'd1);
        check("tie_done_gap", t1 - t0, 10);
        req0 = 1'b0; req1 = 1'b0;

        // Both requests held for four operations: alternating 0,1,0,1.
        @(negedge clk);
        a0 = 8'h01; b0 = 8'h02; a1 = 8'hF0; b1 = 8'h20;
        req0 = 1'b1; req1 = 1'b1;
        push_exp(1'b0, 8'h01, 8'h02);
        push_exp(1'b1, 8'hF0, 8'h20);
        push_exp(1'b0, 8'h01, 8'h02);
        push_exp(1'b1, 8'hF0, 8'h20);
        pulses = 0; n = 0;
        while (pulses < 4 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done != 2'b00) pulses++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_pulses", pulses, 4);
        check("rr_queue_drained", sb_q.size(), 0);

        // Reset during RUN count 4: immediate abort, cleared outputs, no done.
        @(negedge clk);
        a0 = 8'h5A; b0 = 8'h0F; req0 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_gnt", {30'd0, gnt}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) @(negedge clk);
        run_op(1'b0, 8'h22, 8'h11);
        check("post_abort_sum", {24'd0, sum}, 32'h33);

        // Operand change and request drop mid-run: latched operands win, no restart.
        @(negedge clk);
        a0 = 8'h12; b0 = 8'h34; req0 = 1'b1;
        push_exp(1'b0, 8'h12, 8'h34);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a0 = 8'hAA; req0 = 1'b0;
        n = 0;
        while (!done[0] && n < 30) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("drop_done_seen", {31'd0, done[0]}, 32'd1);
        check("drop_sum", {24'd0, sum}, 32'h46);
        busy_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("drop_no_restart", {31'd0, busy_seen}, 32'd0);
        check("final_queue_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Bit-serial two-requester adder scheduler built around one FA full-adder cell.
- Two clients each present N-bit operands. A round-robin arbiter grants the single FA to one client.
- The controller feeds the operands LSB-first through the FA over N cycles, then returns the sum, carry-out and a per-client done pulse.
- Used in the stopwatch/lab datapath wherever occasional additions need not cost an N-bit ripple adder.

Parameters:
- N, 8, operand and sum width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  client 0 request, level, held until done0.
- a0  input  N  client 0 operand A.
- b0  input  N  client 0 operand B.
- req1  input  1  client 1 request, level, held until done1.
- a1  input  N  client 1 operand A.
- b1  input  N  client 1 operand B.
- gnt  output  2  one-hot owner of the adder; 0 when idle.
- busy  output  1  operation in progress (RUN or DONE).
- done  output  2  one-cycle completion pulse, bit i = client i.
- sum  output  N  result of the last completed operation, held until the next completion.
- cout  output  1  carry-out of the last completed operation, held with sum.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- Reset values: gnt=0, busy=0, done=0, sum=0, cout=0, state=IDLE, count=0, carry reg=0, last_served=1 (so client 0 wins the first tie).
- States:
  - IDLE: if any req is high, choose the owner.
    - Only one requesting: that client.
    - Both requesting: the client != last_served.
  - On the accepting edge: latch the owner's a/b into shift regs SA/SB, carry=0, count=0, gnt=onehot(owner), busy=1, go to RUN.
  - No request: stay in IDLE.
  - RUN, each cycle:
    - FA inputs are SA[0], SB[0] and carry.
    - Sum bit shifts into the MSB of shift reg SS; SA and SB shift right; carry<=co; count++.
    - When count==N-1 (the Nth bit processed), go to DONE.
  - DONE, one cycle:
    - sum<=SS (already complete), cout<=carry, done[owner]=1.
    - last_served<=owner; gnt and busy remain asserted this cycle.
    - Next edge: gnt=0, busy=0, done=0, state=IDLE.
- The registered sum/cout become visible in the same cycle done is high. Update them on the RUN->DONE edge using the final bit and final co.
- Latency: request seen in IDLE at edge t. done is high in the cycle after edge t+N+1. Throughput is one op per N+2 cycles.
- Arithmetic: sum = (a+b) mod 2^N, cout = bit N of a+b; unsigned.
- Operands are sampled once at acceptance. Later changes to a/b, or dropping req mid-op, do not affect the result, and the op completes with done still pulsing.
- A request held high after its done is re-arbitrated in the next IDLE cycle. If the other client is requesting, it wins (round robin).
- A request arriving while busy waits; it is never lost as long as it is held.
- Reset mid-operation: abort immediately on the next edge. All outputs return to reset values, no done pulse, and sum/cout are cleared.
- done is never high for both bits at once. gnt is always zero or one-hot.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the client index constants.
- Sub-module: existing FA cell instantiated once; all sequencing, arbitration and shift registers live in serial_add_sched.
- The counter width is clog2(N) and is derived locally.

Test Plan:
1. N=8; pulse req0 with a0=0x35, b0=0x4A, held until done -> gnt=01, busy=1 from next cycle; done0 exactly 9 cycles after acceptance with sum=0x7F, cout=0.
2. req1 with a1=0xFF, b1=0x01 -> done1 with sum=0x00, cout=1; gnt=10 throughout the operation.
3. After reset, raise req0 and req1 in the same cycle (a0=0x10, b0=0x20; a1=0x80, b1=0x80):
   - client 0 is served first: sum=0x30, cout=0.
   - client 1 is accepted in the next IDLE cycle: sum=0x00, cout=1.
   - done1 comes 10 cycles after done0.
4. Hold both requests continuously for 4 operations -> grant order 0,1,0,1, never both done bits set.
5. Raise reset at RUN count 4 of an operation -> next cycle gnt=0, busy=0, sum=0, cout=0, and done never pulses. A new req0 after reset is released completes normally.
6. During RUN, change a0 to 0xAA and drop req0 -> done0 still pulses with the sum of the originally latched operands, and no new operation starts afterwards.
